// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch stage: reset vector, port widths,
// controller state encoding and the fetch-buffer record handed to ID.
package if_fetch_ctrl_pkg;

  localparam logic [31:0] RESET_ADDR = 32'hBFC0_0000;
  localparam int INST_AW = 32;
  localparam int INST_DW = 32;

  typedef enum logic [2:0] {
    IF_BOOT   = 3'd0,
    IF_REQ    = 3'd1,
    IF_WAIT   = 3'd2,
    IF_HOLD   = 3'd3,
    IF_CANCEL = 3'd4
  } if_state_t;

  typedef struct packed {
    logic [INST_AW-1:0] pc;
    logic [INST_DW-1:0] inst;
    logic               adel;
  } if_buf_t;

endpackage

// File: rtl/if_fetch_ctrl.sv
// Fetch controller: single-outstanding SRAM-like requests, one-entry buffer to ID (>=2 cycles addr_ok to valid).
// Backpressure: buffer and PC hold while id_allowin_i=0; a redirect cancels and drains any in-flight fetch.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_ADDR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INST_AW-1:0] pc_i,
  output logic [INST_AW-1:0] nextpc_o,
  output logic               pc_stall_o,
  input  logic               redirect_i,
  input  logic [INST_AW-1:0] redirect_pc_i,
  output logic               inst_req_o,
  output logic [INST_AW-1:0] inst_addr_o,
  input  logic               inst_addr_ok_i,
  input  logic               inst_data_ok_i,
  input  logic [INST_DW-1:0] inst_rdata_i,
  input  logic               id_allowin_i,
  output logic               if_valid_o,
  output logic [INST_AW-1:0] if_pc_o,
  output logic [INST_DW-1:0] if_inst_o,
  output logic               if_adel_o
);

  if_state_t state, state_nxt;
  if_buf_t   ibuf_q, ibuf_d;
  logic      ibuf_vld;
  logic      ibuf_load, ibuf_clr;
  logic      aligned;
  logic      pending;

  assign aligned     = (pc_i[1:0] == 2'b00);
  assign inst_addr_o = pc_i;
  assign inst_req_o  = (state == IF_REQ) && aligned;

  // A request stays outstanding past this cycle if it was already in flight and
  // its data has not come back, or if it is being accepted right now.
  assign pending = (((state == IF_WAIT) || (state == IF_CANCEL)) && !inst_data_ok_i)
                 || (inst_req_o && inst_addr_ok_i);

  always_comb begin
    state_nxt  = state;
    pc_stall_o = 1'b1;
    nextpc_o   = pc_i + 32'd4;
    ibuf_load  = 1'b0;
    ibuf_clr   = 1'b0;
    ibuf_d     = '{pc: pc_i, inst: inst_rdata_i, adel: 1'b0};

    case (state)
      IF_BOOT: begin
        // PC register resets to RESET_PC-4, so this is the same value as pc_i+4.
        pc_stall_o = 1'b0;
        nextpc_o   = RESET_PC;
        state_nxt  = IF_REQ;
      end
      IF_REQ: begin
        if (!aligned) begin
          ibuf_load   = 1'b1;
          ibuf_d.inst = '0;
          ibuf_d.adel = 1'b1;
          state_nxt   = IF_HOLD;
        end else if (inst_addr_ok_i) begin
          state_nxt = IF_WAIT;
        end
      end
      IF_WAIT: begin
        if (inst_data_ok_i) begin
          ibuf_load = 1'b1;
          state_nxt = IF_HOLD;
        end
      end
      IF_HOLD: begin
        if (id_allowin_i) begin
          ibuf_clr   = 1'b1;
          pc_stall_o = 1'b0;
          state_nxt  = IF_REQ;
        end
      end
      IF_CANCEL: begin
        if (inst_data_ok_i) begin
          state_nxt = IF_REQ;
        end
      end
      default: state_nxt = IF_BOOT;
    endcase

    if (redirect_i) begin
      pc_stall_o = 1'b0;
      nextpc_o   = redirect_pc_i;
      ibuf_load  = 1'b0;
      ibuf_clr   = 1'b1;
      state_nxt  = pending ? IF_CANCEL : IF_REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IF_BOOT;
      ibuf_vld <= 1'b0;
      ibuf_q   <= '0;
    end else begin
      state <= state_nxt;
      if (ibuf_clr) begin
        ibuf_vld <= 1'b0;
      end else if (ibuf_load) begin
        ibuf_vld <= 1'b1;
        ibuf_q   <= ibuf_d;
      end
    end
  end

  assign if_valid_o = ibuf_vld;
  assign if_pc_o    = ibuf_q.pc;
  assign if_inst_o  = ibuf_q.inst;
  assign if_adel_o  = ibuf_q.adel;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed vector table, reset-mid-fetch sequence, then
// randomized traffic against a transaction-level model of the fetch stage.
module tb_if_fetch_ctrl;
  import if_fetch_ctrl_pkg::*;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk, reset;
  logic [31:0] pc_i, nextpc_o, redirect_pc_i, inst_addr_o, inst_rdata_i, if_pc_o, if_inst_o;
  logic        pc_stall_o, redirect_i, inst_req_o, inst_addr_ok_i, inst_data_ok_i;
  logic        id_allowin_i, if_valid_o, if_adel_o;

  if_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .pc_i(pc_i), .nextpc_o(nextpc_o), .pc_stall_o(pc_stall_o),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .inst_req_o(inst_req_o),
    .inst_addr_o(inst_addr_o), .inst_addr_ok_i(inst_addr_ok_i), .inst_data_ok_i(inst_data_ok_i),
    .inst_rdata_i(inst_rdata_i), .id_allowin_i(id_allowin_i), .if_valid_o(if_valid_o),
    .if_pc_o(if_pc_o), .if_inst_o(if_inst_o), .if_adel_o(if_adel_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        r;  logic [31:0] rp; logic al; logic ao; logic dd; logic [31:0] rd;
    logic        er; logic        es; logic [31:0] en;
    logic        ev; logic [31:0] ep; logic [31:0] ei; logic ea;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic r, input logic [31:0] rp, input logic al, input logic ao,
                              input logic dd, input logic [31:0] rd, input logic er, input logic es,
                              input logic [31:0] en, input logic ev, input logic [31:0] ep,
                              input logic [31:0] ei, input logic ea);
    vec_t v;
    v.r = r; v.rp = rp; v.al = al; v.ao = ao; v.dd = dd; v.rd = rd;
    v.er = er; v.es = es; v.en = en; v.ev = ev; v.ep = ep; v.ei = ei; v.ea = ea;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [31:0] rp, input logic al, input logic ao,
                       input logic dd, input logic [31:0] rd);
    redirect_i = r; redirect_pc_i = rp; id_allowin_i = al;
    inst_addr_ok_i = ao; inst_data_ok_i = dd; inst_rdata_i = rd;
  endtask

  // PC register: loads nextpc_o unless held, resets to RST_PC-4.
  task automatic edge_step();
    logic [31:0] pn;
    pn = pc_stall_o ? pc_i : nextpc_o;
    @(posedge clk);
    #1;
    pc_i = reset ? RST_PC - 32'd4 : pn;
  endtask

  task automatic chk_outs(input string tag, input logic er, input logic es, input logic [31:0] en,
                          input logic ev, input logic [31:0] ep, input logic [31:0] ei, input logic ea);
    chk({tag, " req"},   32'(inst_req_o), 32'(er));
    chk({tag, " stall"}, 32'(pc_stall_o), 32'(es));
    chk({tag, " nextpc"}, nextpc_o, en);
    chk({tag, " valid"}, 32'(if_valid_o), 32'(ev));
    if (er) chk({tag, " addr"}, inst_addr_o, pc_i);
    if (ev) begin
      chk({tag, " if_pc"},   if_pc_o, ep);
      chk({tag, " if_inst"}, if_inst_o, ei);
      chk({tag, " if_adel"}, 32'(if_adel_o), 32'(ea));
    end
  endtask

  // Transaction-level reference: buffer contents, whether a request is in flight,
  // whether its data must be dropped, and whether the PC still needs its boot step.
  logic        m_boot, m_out, m_drop, m_vld, m_adel;
  logic [31:0] m_pc, m_inst;
  logic        mem_busy;
  int          mem_cnt;
  logic [31:0] mem_word;

  task automatic model_reset();
    m_boot = 1'b1; m_out = 1'b0; m_drop = 1'b0; m_vld = 1'b0;
    m_pc = '0; m_inst = '0; m_adel = 1'b0;
    mem_busy = 1'b0; mem_cnt = 0; mem_word = '0;
  endtask

  initial begin
    logic        r, al, ao, dd, e_req, e_stall;
    logic [31:0] rp, rd, e_npc;

    // c0..c4: boot, request accepted a cycle late, data two cycles after that
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,            0, 0, 32'hBFC0_0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,            1, 1, 32'hBFC0_0004, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0,            1, 1, 32'hBFC0_0004, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,            0, 1, 32'hBFC0_0004, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h2408_0001, 0, 1, 32'hBFC0_0004, 0, 0, 0, 0));
    repeat (5) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'hBFC0_0004, 1, 32'hBFC0_0000, 32'h2408_0001, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0,            0, 0, 32'hBFC0_0004, 1, 32'hBFC0_0000, 32'h2408_0001, 0));
    // redirect during WAIT: late data dropped, refetch at target
    tbl.push_back(mk(0, 0, 0, 1, 0, 0,            1, 1, 32'hBFC0_0008, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h8000_0180, 0, 0, 0, 0, 0, 0, 32'h8000_0180, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,            0, 1, 32'h8000_0184, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 1, 32'h8000_0184, 0, 0, 0, 0));
    // redirect coincident with addr_ok
    tbl.push_back(mk(1, 32'h8000_0200, 0, 1, 0, 0, 1, 0, 32'h8000_0200, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h1111_1111, 0, 1, 32'h8000_0204, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0,            1, 1, 32'h8000_0204, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h2222_2222, 0, 1, 32'h8000_0204, 0, 0, 0, 0));
    // redirect beats an ID handshake, target misaligned
    tbl.push_back(mk(1, 32'h8000_0002, 1, 0, 0, 0, 0, 0, 32'h8000_0002, 1, 32'h8000_0200, 32'h2222_2222, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,            0, 1, 32'h8000_0006, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,            0, 1, 32'h8000_0006, 1, 32'h8000_0002, 0, 1));
    // wrap-around at the top of the address space
    tbl.push_back(mk(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 1, 32'h8000_0002, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0,            1, 1, 32'h0000_0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h3333_3333, 0, 1, 32'h0000_0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0,            0, 0, 32'h0000_0000, 1, 32'hFFFF_FFFC, 32'h3333_3333, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0,            1, 1, 32'h0000_0004, 0, 0, 0, 0));

    reset = 1'b1;
    pc_i  = RST_PC - 32'd4;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst valid", 32'(if_valid_o), 32'd0);
    chk("rst if_pc", if_pc_o, 32'd0);
    chk("rst if_inst", if_inst_o, 32'd0);
    chk("rst if_adel", 32'(if_adel_o), 32'd0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].rp, tbl[i].al, tbl[i].ao, tbl[i].dd, tbl[i].rd);
      #2;
      chk_outs($sformatf("vec%0d", i), tbl[i].er, tbl[i].es, tbl[i].en,
               tbl[i].ev, tbl[i].ep, tbl[i].ei, tbl[i].ea);
      edge_step();
    end

    // reset while a fetch is outstanding: straight back to boot, no data_ok awaited
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    edge_step();
    reset = 1'b0;
    #2;
    chk_outs("midrst boot", 0, 0, RST_PC, 0, 0, 0, 0);
    edge_step();
    #2;
    chk_outs("midrst req", 1, 1, RST_PC + 32'd4, 0, 0, 0, 0);

    reset = 1'b1;
    edge_step();
    reset = 1'b0;
    model_reset();

    for (int cyc = 0; cyc < 4000; cyc++) begin
      #1;
      if ($urandom_range(399) == 0) begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        edge_step();
        reset = 1'b0;
        model_reset();
      end else begin
        r  = ($urandom_range(15) == 0);
        rp = $urandom();
        if ($urandom_range(7) != 0) rp[1:0] = 2'b00;
        al = 1'(($urandom_range(1)));
        ao = inst_req_o && !mem_busy && ($urandom_range(1) == 1);
        dd = mem_busy && (mem_cnt == 0);
        rd = dd ? mem_word : $urandom();
        drive(r, rp, al, ao, dd, rd);
        #1;

        e_req   = !m_boot && !m_out && !m_vld && (pc_i[1:0] == 2'b00);
        e_stall = !(m_boot || r || (m_vld && al));
        e_npc   = r ? rp : pc_i + 32'd4;
        chk_outs($sformatf("rnd%0d", cyc), e_req, e_stall, e_npc, m_vld, m_pc, m_inst, m_adel);

        if (r) begin
          m_vld  = 1'b0;
          m_out  = (m_out && !dd) || (e_req && ao);
          m_drop = m_out;
          m_boot = 1'b0;
        end else if (m_boot) begin
          m_boot = 1'b0;
        end else if (m_vld) begin
          if (al) m_vld = 1'b0;
        end else if (m_out) begin
          if (dd) begin
            if (!m_drop) begin
              m_vld = 1'b1; m_pc = pc_i; m_inst = rd; m_adel = 1'b0;
            end
            m_out  = 1'b0;
            m_drop = 1'b0;
          end
        end else if (pc_i[1:0] != 2'b00) begin
          m_vld = 1'b1; m_pc = pc_i; m_inst = '0; m_adel = 1'b1;
        end else if (ao) begin
          m_out = 1'b1;
        end

        if (dd) mem_busy = 1'b0;
        else if (mem_busy) mem_cnt--;
        if (ao) begin
          mem_busy = 1'b1;
          mem_cnt  = $urandom_range(2);
          mem_word = $urandom();
        end
        edge_step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
